// File: rtl/perceptron_sequencer.sv
// Perceptron sequencer: weight/threshold regfile plus one serial saturating adder; result N_INPUTS+1 edges after start.
// Config writes and starts are accepted only in IDLE (cfg_ready low while busy); starts while busy are dropped.
module perceptron_sequencer #(
  parameter int N_INPUTS  = 8,
  parameter int W_WIDTH   = 4,
  parameter int ACC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [3:0]           cfg_addr,
  input  logic [ACC_WIDTH-1:0] cfg_data,
  input  logic                 start,
  input  logic [N_INPUTS-1:0]  x_in,
  output logic                 busy,
  output logic                 done,
  output logic                 fire,
  output logic [ACC_WIDTH-1:0] sum
);

  localparam int IDX_W = $clog2(N_INPUTS);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_INPUTS - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FINISH
  } state_e;

  state_e               state_q, state_d;
  logic [W_WIDTH-1:0]   w_q [N_INPUTS];
  logic [W_WIDTH-1:0]   w_d [N_INPUTS];
  logic [ACC_WIDTH-1:0] thr_q, thr_d;
  logic [N_INPUTS-1:0]  x_q, x_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic                 fire_q, fire_d;
  logic                 done_q, done_d;

  logic [W_WIDTH-1:0]   w_sel;
  logic [ACC_WIDTH:0]   add_ext;
  logic [ACC_WIDTH-1:0] acc_sat;

  // One guard bit catches overflow; the two top bits disagree exactly when the result left the range.
  assign w_sel   = w_q[idx_q];
  assign add_ext = {acc_q[ACC_WIDTH-1], acc_q}
                 + {{(ACC_WIDTH+1-W_WIDTH){w_sel[W_WIDTH-1]}}, w_sel};
  assign acc_sat = (add_ext[ACC_WIDTH] != add_ext[ACC_WIDTH-1])
                 ? (add_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                 : add_ext[ACC_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    thr_d   = thr_q;
    x_d     = x_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    fire_d  = fire_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          for (int i = 0; i < N_INPUTS; i++) begin
            if (cfg_addr == 4'(i)) w_d[i] = cfg_data[W_WIDTH-1:0];
          end
          if (cfg_addr == 4'(N_INPUTS)) thr_d = cfg_data;
        end
        if (start) begin
          x_d     = x_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (x_q[idx_q]) acc_d = acc_sat;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = S_FINISH;
      end
      S_FINISH: begin
        sum_d   = acc_q;
        fire_d  = $signed(acc_q) >= $signed(thr_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < N_INPUTS; i++) w_q[i] <= '0;
      thr_q   <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      fire_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      thr_q   <= thr_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      fire_q  <= fire_d;
      done_q  <= done_d;
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign fire      = fire_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_perceptron_sequencer.sv
// Bench for perceptron_sequencer: an 8-bit and a 6-bit accumulator instance share one stimulus stream
// and are compared every cycle against a per-evaluation arithmetic model, plus literal spot checks.
module tb_perceptron_sequencer;

  localparam int NI = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic       start = 1'b0;
  logic [7:0] x_in = '0;

  logic       cfg_ready8, busy8, done8, fire8;
  logic [7:0] sum8;
  logic       cfg_ready6, busy6, done6, fire6;
  logic [5:0] sum6;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perceptron_sequencer #(.N_INPUTS(NI), .W_WIDTH(4), .ACC_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready8),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .x_in(x_in),
    .busy(busy8), .done(done8), .fire(fire8), .sum(sum8)
  );

  perceptron_sequencer #(.N_INPUTS(NI), .W_WIDTH(4), .ACC_WIDTH(6)) u_dut6 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready6),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data[5:0]), .start(start), .x_in(x_in),
    .busy(busy6), .done(done6), .fire(fire6), .sum(sum6)
  );

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: whole evaluation computed at start time, results released N+1 edges later.
  int  m_w [NI];
  int  m_thr8, m_thr6;
  int  m_phase;
  int  p_sum8, p_sum6;
  bit  p_f8, p_f6;
  int  e_sum8, e_sum6;
  bit  e_f8, e_f6, e_done;
  bit  m_ok = 1'b0;

  function automatic int eval_sum(input int aw, input logic [7:0] x);
    int acc = 0;
    int lo = -(1 << (aw - 1));
    int hi = (1 << (aw - 1)) - 1;
    for (int i = 0; i < NI; i++) begin
      if (x[i]) begin
        acc = acc + m_w[i];
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
      end
    end
    return acc;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) m_w[i] = 0;
      m_thr8 = 0; m_thr6 = 0; m_phase = 0;
      e_sum8 = 0; e_sum6 = 0; e_f8 = 0; e_f6 = 0; e_done = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      e_done = 0;
      if (m_phase == 0) begin
        if (cfg_valid) begin
          if (cfg_addr < 4'(NI)) m_w[cfg_addr] = int'($signed(cfg_data[3:0]));
          else if (cfg_addr == 4'(NI)) begin
            m_thr8 = int'($signed(cfg_data));
            m_thr6 = int'($signed(cfg_data[5:0]));
          end
        end
        if (start) begin
          p_sum8 = eval_sum(8, x_in);
          p_sum6 = eval_sum(6, x_in);
          p_f8 = (p_sum8 >= m_thr8);
          p_f6 = (p_sum6 >= m_thr6);
          m_phase = 1;
        end
      end else if (m_phase == NI + 1) begin
        e_sum8 = p_sum8; e_sum6 = p_sum6;
        e_f8 = p_f8; e_f6 = p_f6;
        e_done = 1;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("busy8", busy8, m_phase != 0);
      chk("cfg_ready8", cfg_ready8, m_phase == 0);
      chk("done8", done8, e_done);
      chk("fire8", fire8, e_f8);
      chk("sum8", $signed(sum8), e_sum8);
      chk("busy6", busy6, m_phase != 0);
      chk("cfg_ready6", cfg_ready6, m_phase == 0);
      chk("done6", done6, e_done);
      chk("fire6", fire6, e_f6);
      chk("sum6", $signed(sum6), e_sum6);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic run(input logic [7:0] x);
    int lat;
    start = 1'b1; x_in = x;
    tick();
    start = 1'b0; x_in = 8'($urandom);
    lat = 0;
    while (!done8 && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", lat, 9);
  endtask

  initial begin
    int dcnt;
    tick(); tick();
    rst = 1'b0;
    chk("reset_sum", $signed(sum8), 0);
    chk("reset_ready", cfg_ready8, 1);

    run(8'hFF);
    chk("zero_w_sum", $signed(sum8), 0);
    chk("zero_w_fire", fire8, 1);

    for (int i = 0; i < NI; i++) write(4'(i), 8'd1);
    write(4'(NI), 8'd3);
    run(8'h0F);
    chk("ones_0F_sum", $signed(sum8), 4);
    chk("ones_0F_fire", fire8, 1);
    run(8'h03);
    chk("ones_03_sum", $signed(sum8), 2);
    chk("ones_03_fire", fire8, 0);

    // Config and start hammered while busy: neither may take effect.
    start = 1'b1; x_in = 8'hFF;
    tick();
    cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 8'd7;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) chk("busy_ready", cfg_ready8, 0);
      if (i == 5) begin cfg_valid = 1'b0; start = 1'b0; end
      tick();
      if (done8) dcnt++;
    end
    chk("busy_done_count", dcnt, 1);
    chk("busy_sum", $signed(sum8), 8);

    cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 8'd5;
    run(8'h01);
    cfg_valid = 1'b0;
    chk("same_edge_sum", $signed(sum8), 5);

    for (int i = 0; i < NI; i++) write(4'(i), 8'(i - 4));
    write(4'(NI), 8'hFB);
    run(8'hA5);
    chk("mixed_sum8", $signed(sum8), -2);
    chk("mixed_sum6", $signed(sum6), -2);
    chk("mixed_fire", fire8, 1);
    write(4'(NI), 8'd0);
    run(8'hA5);
    chk("mixed_thr0_fire", fire8, 0);

    for (int i = 0; i < NI; i++) write(4'(i), 8'd7);
    run(8'hFF);
    chk("pos_sum8", $signed(sum8), 56);
    chk("pos_sat6", $signed(sum6), 31);
    for (int i = 0; i < NI; i++) write(4'(i), 8'hF8);
    run(8'hFF);
    chk("neg_sum8", $signed(sum8), -64);
    chk("neg_sat6", $signed(sum6), -32);

    // Reset in the fourth ACCUM cycle aborts and wipes the register file.
    start = 1'b1; x_in = 8'hFF;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_sum", $signed(sum8), 0);
    chk("abort_fire", fire8, 0);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done8) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run(8'hFF);
    chk("cleared_sum", $signed(sum8), 0);

    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_addr  = 4'($urandom_range(0, 10));
      cfg_data  = 8'($urandom);
      start     = ($urandom_range(0, 3) == 0);
      x_in      = 8'($urandom);
      tick();
    end
    rst = 1'b0; cfg_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
